// File: rtl/data_mem_resp_if.sv
// Memory-stage request/response bundle for the data memory responder.
// The master side issues requests; the slave side returns completion.
interface data_mem_resp_if;
    logic        MemCE_i;
    logic        MemWE_i;
    logic [31:0] MemAddr_i;
    logic [31:0] MemData_i;
    logic [31:0] MemData_o;
    logic        MemReady_o;
    logic        MemErr_o;
    logic        MemBusy_o;

    modport master (
        output MemCE_i, MemWE_i, MemAddr_i, MemData_i,
        input  MemData_o, MemReady_o, MemErr_o, MemBusy_o
    );

    modport slave (
        input  MemCE_i, MemWE_i, MemAddr_i, MemData_i,
        output MemData_o, MemReady_o, MemErr_o, MemBusy_o
    );
endinterface

// File: rtl/data_mem_resp.sv
// Word-addressed data memory with a fixed-latency IDLE/BUSY/DONE handshake.
// One request is held at a time; completion is a single-cycle ready pulse.
module data_mem_resp #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst,
    data_mem_resp_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    state_t      state_nx;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nx;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [29:0] idx;
    logic [AW-1:0] waddr;
    logic        bad;
    logic        fire;
    logic        accept;

    logic [31:0] mem [DEPTH];

    assign idx    = addr_q[31:2];
    assign waddr  = idx[AW-1:0];
    assign bad    = (addr_q[1:0] != 2'b00) || ({2'b00, idx} >= 32'(DEPTH));
    assign fire   = (state == BUSY) && (cnt == 4'd0);
    assign accept = (state == IDLE) && bus.MemCE_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (bus.MemCE_i) begin
                    state_nx = BUSY;
                    cnt_nx   = 4'(LATENCY - 1);
                end
            end
            BUSY: begin
                if (cnt != 4'd0) cnt_nx = cnt - 4'd1;
                else             state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Request fields only matter once accepted; reset discards via state.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= bus.MemAddr_i;
            we_q    <= bus.MemWE_i;
            wdata_q <= bus.MemData_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (fire) begin
            err_q <= bad;
            if (bad)        rdata_q <= 32'd0;
            else if (!we_q) rdata_q <= mem[waddr];
        end
    end

    // Storage is never reset; an aborted store must not land.
    always_ff @(posedge clk) begin
        if (fire && we_q && !bad && !rst)
            mem[waddr] <= wdata_q;
    end

    assign bus.MemData_o  = rdata_q;
    assign bus.MemReady_o = (state == DONE);
    assign bus.MemErr_o   = (state == DONE) && err_q;
    assign bus.MemBusy_o  = (state != IDLE);
endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp at LATENCY=2 and LATENCY=1.
// Table-driven accesses plus hand-written back-to-back and reset sequences.
module tb_data_mem_resp;
    logic clk = 1'b0;
    logic rst;
    logic mon_on = 1'b0;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    data_mem_resp_if m2();
    data_mem_resp_if m1();

    data_mem_resp #(.DEPTH(1024), .LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .bus(m2.slave)
    );
    data_mem_resp #(.DEPTH(1024), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .bus(m1.slave)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tv2[12];
    vec_t tv1[5];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    task automatic drive(input bit s, input logic ce, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
        if (s) begin
            m1.MemCE_i = ce; m1.MemWE_i = we;
            m1.MemAddr_i = a; m1.MemData_i = d;
        end else begin
            m2.MemCE_i = ce; m2.MemWE_i = we;
            m2.MemAddr_i = a; m2.MemData_i = d;
        end
    endtask

    function automatic logic rdy(input bit s);
        return s ? m1.MemReady_o : m2.MemReady_o;
    endfunction
    function automatic logic err(input bit s);
        return s ? m1.MemErr_o : m2.MemErr_o;
    endfunction
    function automatic logic bsy(input bit s);
        return s ? m1.MemBusy_o : m2.MemBusy_o;
    endfunction
    function automatic logic [31:0] dat(input bit s);
        return s ? m1.MemData_o : m2.MemData_o;
    endfunction

    // Single request: accept, measure latency, check result and hold.
    task automatic access(input bit s, input int lat, input string nm,
                          input vec_t v);
        bit seen = 1'b0;
        @(negedge clk);
        drive(s, 1'b1, v.we, v.addr, v.wdata);
        @(posedge clk);
        #1 drive(s, 1'b0, 1'b0, 32'd0, 32'd0);
        chk({nm, " busy"}, 32'(bsy(s)), 32'd1);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (rdy(s)) begin
                seen = 1'b1;
                chk({nm, " latency"}, k, lat);
                chk({nm, " err"}, 32'(err(s)), 32'(v.exp_err));
                chk({nm, " data"}, dat(s), v.exp_data);
                break;
            end
        end
        chk({nm, " ready seen"}, 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        chk({nm, " pulse width"}, 32'(rdy(s)), 32'd0);
        chk({nm, " idle"}, 32'(bsy(s)), 32'd0);
        chk({nm, " hold"}, dat(s), v.exp_data);
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            chk("err gate L2", 32'(m2.MemErr_o & ~m2.MemReady_o), 32'd0);
            chk("err gate L1", 32'(m1.MemErr_o & ~m1.MemReady_o), 32'd0);
        end
    end

    initial begin
        int np;
        int tk[3];
        logic [31:0] td[3];
        logic te[3];

        tv2[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
        tv2[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        tv2[2]  = '{1'b1, 32'h0000_0012, 32'h1234_5678, 1'b1, 32'h0};
        tv2[3]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        tv2[4]  = '{1'b0, 32'h0000_0012, 32'h0,         1'b1, 32'h0};
        tv2[5]  = '{1'b0, 32'h0000_1000, 32'h0,         1'b1, 32'h0};
        tv2[6]  = '{1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 1'b0, 32'h0};
        tv2[7]  = '{1'b0, 32'h0000_0FFC, 32'h0,         1'b0, 32'hCAFE_F00D};
        tv2[8]  = '{1'b1, 32'h0000_0020, 32'h1111_2222, 1'b0, 32'hCAFE_F00D};
        tv2[9]  = '{1'b0, 32'h0000_0020, 32'h0,         1'b0, 32'h1111_2222};
        tv2[10] = '{1'b1, 32'h4000_0000, 32'h9999_9999, 1'b1, 32'h0};
        tv2[11] = '{1'b0, 32'h0000_0FFC, 32'h0,         1'b0, 32'hCAFE_F00D};

        tv1[0] = '{1'b1, 32'h0000_0008, 32'h1357_9BDF, 1'b0, 32'h0};
        tv1[1] = '{1'b0, 32'h0000_0008, 32'h0,         1'b0, 32'h1357_9BDF};
        tv1[2] = '{1'b0, 32'h0000_0009, 32'h0,         1'b1, 32'h0};
        tv1[3] = '{1'b1, 32'h0000_1000, 32'h2468_ACE0, 1'b1, 32'h0};
        tv1[4] = '{1'b0, 32'h0000_0008, 32'h0,         1'b0, 32'h1357_9BDF};

        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mon_on = 1'b1;
        chk("reset ready", 32'(m2.MemReady_o), 32'd0);
        chk("reset busy", 32'(m2.MemBusy_o), 32'd0);
        chk("reset err", 32'(m2.MemErr_o), 32'd0);
        chk("reset data", m2.MemData_o, 32'd0);

        for (int i = 0; i < 12; i++)
            access(1'b0, 2, $sformatf("L2 vec%0d", i), tv2[i]);

        // Back-to-back with CE held; inputs retargeted mid-BUSY.
        np = 0;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 32'h30, 32'h5A5A_0001);
        for (int k = 0; k <= 13; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) drive(1'b0, 1'b1, 1'b0, 32'h30, 32'h0);
            if (k == 5) drive(1'b0, 1'b1, 1'b1, 32'h30, 32'h5A5A_0002);
            if (k == 9) drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            if (m2.MemReady_o) begin
                if (np < 3) begin
                    tk[np] = k;
                    td[np] = m2.MemData_o;
                    te[np] = m2.MemErr_o;
                end
                np++;
            end
        end
        chk("b2b pulses", np, 3);
        if (np >= 3) begin
            chk("b2b t0", tk[0], 2);
            chk("b2b t1", tk[1], 6);
            chk("b2b t2", tk[2], 10);
            chk("b2b load data", td[1], 32'h5A5A_0001);
            chk("b2b store keeps data", td[2], 32'h5A5A_0001);
            chk("b2b err", 32'({te[0], te[1], te[2]}), 32'd0);
        end
        access(1'b0, 2, "b2b reload", '{1'b0, 32'h30, 32'h0, 1'b0, 32'h5A5A_0002});

        // Reset in the first BUSY cycle aborts a pending store.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 32'h20, 32'hAAAA_5555);
        @(posedge clk);
        #1 drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("abort busy", 32'(m2.MemBusy_o), 32'd0);
        chk("abort data", m2.MemData_o, 32'd0);
        chk("abort err", 32'(m2.MemErr_o), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1 chk("abort no ready", 32'(m2.MemReady_o), 32'd0);
        end

        // Reset wins over a request presented in the same cycle.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h7777_7777);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("rst prio busy", 32'(m2.MemBusy_o), 32'd0);
        repeat (3) @(posedge clk);
        #1 chk("rst prio no ready", 32'(m2.MemReady_o), 32'd0);
        access(1'b0, 2, "after abort", '{1'b0, 32'h20, 32'h0, 1'b0, 32'h1111_2222});

        for (int i = 0; i < 5; i++)
            access(1'b1, 1, $sformatf("L1 vec%0d", i), tv1[i]);

        repeat (2) @(posedge clk);
        mon_on = 1'b0;
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameter DEPTH, default 1024: number of 32-bit words of storage.
REQ-002 Parameter LATENCY, default 2: number of BUSY cycles per access; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 MemCE_i  input  1  request strobe from the memory stage.
REQ-006 MemWE_i  input  1  1 = store (sw), 0 = load (lw); sampled with MemCE_i.
REQ-007 MemAddr_i  input  32  byte address of the access.
REQ-008 MemData_i  input  32  store data.
REQ-009 MemData_o  output  32  load data returned to the memory stage.
REQ-010 MemReady_o  output  1  one-cycle completion pulse for the accepted request.
REQ-011 MemErr_o  output  1  completion status; valid only while MemReady_o=1.
REQ-012 MemBusy_o  output  1  high while a request is held (BUSY or DONE); no new request is accepted.

Function
REQ-013 The FSM SHALL have states IDLE, BUSY and DONE, with a 4-bit down-counter.
REQ-014 In IDLE with MemCE_i=1, the block SHALL latch MemAddr_i, MemWE_i and MemData_i, load the counter with LATENCY-1 and go to BUSY.
REQ-015 In IDLE with MemCE_i=0, the block SHALL stay in IDLE.
REQ-016 In BUSY, inputs SHALL be ignored; if counter!=0 it SHALL decrement, else the access SHALL be performed and the state SHALL go to DONE.
REQ-017 BUSY SHALL last exactly LATENCY cycles, so MemReady_o is high during the cycle after edge E+LATENCY, where E is the acceptance edge.
REQ-018 In DONE, MemReady_o SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE unconditionally.
REQ-019 Minimum request spacing SHALL be LATENCY+2 cycles; a MemCE_i held high across DONE SHALL be accepted as a new request in the following IDLE cycle.
REQ-020 Word index SHALL be latched_addr[31:2].
REQ-021 An access SHALL be an error if addr[1:0]!=0 or word index >= DEPTH.
REQ-022 Legal store: mem[index] SHALL be updated with the latched data at the BUSY->DONE edge; MemData_o SHALL be unchanged; MemErr_o=0.
REQ-023 Legal load: MemData_o SHALL be set to mem[index] at the BUSY->DONE edge; MemErr_o=0.
REQ-024 MemData_o SHALL hold that value until the next load completes.
REQ-025 Error access: no memory write SHALL occur; MemData_o SHALL be set to 0; MemErr_o=1 during the DONE cycle.
REQ-026 MemErr_o SHALL be 0 whenever MemReady_o=0.
REQ-027 A load of a word SHALL return the most recent completed store to that word, including a store immediately preceding it.
REQ-028 MemBusy_o SHALL equal (state!=IDLE).

Reset
REQ-029 When rst=1 at a clock edge, state SHALL become IDLE, counter 0, MemData_o=0, MemReady_o=0, MemErr_o=0 and MemBusy_o=0.
REQ-030 Reset SHALL take priority over MemCE_i; a request presented in the reset cycle SHALL be discarded.
REQ-031 Reset asserted in BUSY SHALL abort the pending access; a pending store SHALL NOT modify memory.
REQ-032 Storage contents SHALL NOT be cleared by reset; contents are undefined until written.

Verification
REQ-033 Store then load, LATENCY=2: sw 0x0000_0010 <- 0xDEAD_BEEF, accepted at edge E -> MemReady_o high after E+2 with MemErr_o=0; then lw 0x10 -> MemData_o=0xDEAD_BEEF with the ready pulse.
REQ-034 Back-to-back, MemCE_i held high: 3 requests complete with MemReady_o pulses exactly LATENCY+2 cycles apart; input changes during BUSY do not alter the latched request.
REQ-035 Misaligned: sw 0x0000_0012 <- 0x1234_5678 -> MemErr_o=1 for the ready cycle; subsequent lw 0x10 returns the prior value unchanged; lw 0x12 -> MemData_o=0, MemErr_o=1.
REQ-036 Out of range with DEPTH=1024: lw 0x0000_1000 -> MemErr_o=1, MemData_o=0; lw 0x0000_0FFC is legal.
REQ-037 Reset mid-op: sw 0x20 <- 0xAAAA_5555, rst=1 in first BUSY cycle -> no MemReady_o pulse, outputs 0; lw 0x20 afterwards returns the previous contents, not 0xAAAA_5555.
REQ-038 LATENCY=1 sweep: ready pulse appears after edge E+1; DONE always returns to IDLE; MemErr_o is never high outside the ready cycle.
